mux_n_to_1_arb: RTL and testbench
=================================

# mux_n_to_1_arb

Parametrised N-input arbitrating multiplexer with a registered, valid/ready-handshaked output stage. It selects one of `NUM_INPUTS` requesting sources, captures that source's data into a one-entry output register, and reports which source won. It is used wherever several pipeline producers share one consumer, such as writeback sources or memory-request ports. It generalises the fixed 3-way combinational select into an N-way, flow-controlled, sequential block.

## Interface
- `DATA_WIDTH`, 32, width of each data channel.
- `NUM_INPUTS`, 4, number of source channels; legal range 2..16.
- `SEL_WIDTH`, `$clog2(NUM_INPUTS)`, derived width of the source index; must not be overridden.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of the held output entry.
- `in_data`  in  `NUM_INPUTS*DATA_WIDTH`  flattened source data; channel i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid`  in  `NUM_INPUTS`  per-source request.
- `in_ready`  out  `NUM_INPUTS`  per-source accept; at most one bit is high in any cycle (one-hot or zero).
- `out_data`  out  `DATA_WIDTH`  registered selected data.
- `out_sel`  out  `SEL_WIDTH`  index of the source that supplied `out_data`.
- `out_valid`  out  1  output entry is valid.
- `out_ready`  in  1  consumer accepts the output entry.

## Operation
- **Storage.** The block holds one output register entry: `out_data`, `out_sel` and `out_valid`.
- **Load enable.** `load_en = !out_valid || out_ready`, forced to 0 while `flush` is high.
- **Grant.** The grant is combinational over `in_valid`, starting from priority pointer `ptr`.
  - The winner is the first index i, scanning `ptr, ptr+1, ..., NUM_INPUTS-1, 0, ..., ptr-1`, with `in_valid[i]=1`.
  - `in_ready[i] = load_en && (i == winner)`.
  - If no `in_valid` bit is set, `in_ready` is all zero.
- **Transfer on the input side.** A transfer happens when `in_valid[i] && in_ready[i]`. On that edge:
  - `out_data` ← channel i.
  - `out_sel` ← i.
  - `out_valid` ← 1.
- **Consume with no refill.** If the output is consumed (`out_valid && out_ready`) and no input transfer happens, `out_valid` ← 0. `out_data` and `out_sel` keep their old values.
- **Backpressure.** While `out_valid && !out_ready`, `out_data` and `out_sel` are held stable and all `in_ready` bits are 0.
- **Pointer update.** After an input transfer from source i, `ptr` ← (i+1) mod `NUM_INPUTS`, wrapping from `NUM_INPUTS-1` to 0. `ptr` does not change in cycles without a transfer.
- **Flush.**
  - `out_valid` ← 0 on the next edge, whatever the state of `out_ready`.
  - No input is accepted in the flush cycle.
  - `ptr`, `out_data` and `out_sel` are unchanged.
  - Flush takes priority over a simultaneous consume or load.
- **Source rule.** A source must hold its data stable while its `in_valid` is high and it is not yet accepted. The block never drops or duplicates an accepted entry.

## Timing
- **Reset values** (asynchronous on the falling edge of `rst_n`, held until release):
  - `out_valid`=0.
  - `out_data`=0.
  - `out_sel`=0.
  - `ptr`=0.
  - `in_ready`=0, because `in_valid` is ignored until the first clock edge after release.
- **Latency.** From input transfer to `out_valid` is 1 cycle.
- **Throughput.** One transfer per cycle when `out_ready` is held high.
- **Combinational paths.** `in_ready` depends combinationally on `in_valid`, `out_ready`, `flush` and `ptr`. There is no path from `in_valid` to `out_valid`.
- **Simultaneous consume and load.** In the same cycle, the output is replaced with no bubble.
- **Reset mid-operation.** A pending entry is discarded and `ptr` returns to 0.

## Configuration
- **Macro:** `MUX_ARB_ROUND_ROBIN_EN`.
- **Defined:** the rotating-priority behaviour described under Operation.
- **Undefined:** fixed priority.
  - `ptr` is removed and the lowest valid index always wins.
  - All other behaviour and the interface are identical.

## Test plan
All scenarios use `DATA_WIDTH`=32 and `NUM_INPUTS`=4.

- **Reset.** Assert `rst_n`=0 mid-stream with `out_valid`=1 → `out_valid`=0, `out_data`=0, `out_sel`=0 immediately. The first grant after release goes to source 0 when all sources are valid.
- **Round-robin rotation.** All four `in_valid`=1 with data 0xA0..0xA3 and `out_ready`=1 for 8 cycles → `out_sel` sequence 0,1,2,3,0,1,2,3 with one transfer per cycle. Without the macro: 0,0,0,...
- **Backpressure.** Output holds 0xA1 with `out_ready`=0 for 5 cycles while all inputs are valid → `out_data`=0xA1 and `out_sel`=1 stable, `in_ready`=0000. On the first cycle with `out_ready`=1, `in_ready`=0100 and the next `out_sel`=2.
- **Sparse requests.** Only `in_valid`=1001 with `ptr`=1 → source 3 wins, then `ptr` wraps to 0 and source 0 wins next.
- **Flush.** `flush`=1 with `out_valid`=1 and `out_ready`=1 and `in_valid`=1111 → next cycle `out_valid`=0, `in_ready`=0000 during the flush cycle, and `ptr` unchanged.
- **Idle drain.** A single transfer, then `in_valid`=0000 with `out_ready`=1 → `out_valid` goes 1 then 0, and `out_data` retains its last value.

Source files
------------

// File: rtl/mux_n_to_1_arb.sv
// N-input arbitrating mux with a one-entry valid/ready output register.
// Define MUX_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest valid index wins.
module mux_n_to_1_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]          in_valid,
    output logic [NUM_INPUTS-1:0]          in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]           out_sel,
    output logic                           out_valid,
    input  logic                           out_ready
);

    logic                  r_live;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_WIDTH-1:0]  r_out_sel;

    logic [SEL_WIDTH-1:0]  w_base;
    logic [SEL_WIDTH-1:0]  w_win;
    logic [SEL_WIDTH:0]    w_sum;
    logic                  w_any;
    logic                  w_load_en;
    logic                  w_xfer;

`ifdef MUX_ARB_ROUND_ROBIN_EN
    logic [SEL_WIDTH-1:0]  r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_win == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : w_win + 1'b1;
        end
    end

    assign w_base = r_ptr;
`else
    assign w_base = '0;
`endif

    // Scan from w_base with wraparound; first requester found wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_sum = {1'b0, w_base} + (SEL_WIDTH+1)'(k);
            if (w_sum >= (SEL_WIDTH+1)'(NUM_INPUTS))
                w_sum = w_sum - (SEL_WIDTH+1)'(NUM_INPUTS);
            if (!w_any && in_valid[w_sum[SEL_WIDTH-1:0]]) begin
                w_any = 1'b1;
                w_win = w_sum[SEL_WIDTH-1:0];
            end
        end
    end

    // r_live keeps in_ready low until the first edge after reset release.
    assign w_load_en = r_live && !flush && (!r_out_valid || out_ready);
    assign w_xfer    = w_load_en && w_any;

    always_comb begin
        in_ready = '0;
        if (w_xfer)
            in_ready[w_win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_win*DATA_WIDTH +: DATA_WIDTH];
                r_out_sel   <= w_win;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_n_to_1_arb.sv
// Scoreboard bench for mux_n_to_1_arb (4 x 32-bit); expectations follow MUX_ARB_ROUND_ROBIN_EN.
module tb_mux_n_to_1_arb;

`ifdef MUX_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   s;

    mux_n_to_1_arb #(.DATA_WIDTH(32), .NUM_INPUTS(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] v, input logic [31:0] base);
        in_valid = v;
        for (int i = 0; i < 4; i++)
            in_data[i*32 +: 32] = base + 32'(i);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle in which source sel is expected to be accepted.
    task automatic issue(input int sel, input logic [31:0] base);
        exp_t e;
        logic [3:0] rdy;
        e.sel  = 2'(sel);
        e.data = base + 32'(sel);
        exp_q.push_back(e);
        rdy = 4'b0001 << sel;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        next_cyc();
    endtask

    // Monitor: compare every consumed entry; a flushed entry is dropped from the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (flush) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got sel %0d data %0h expected none", out_sel, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sel", 32'(out_sel), 32'(e.sel));
                    chk("out_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_in(4'b1111, 32'hA0);
        repeat (2) next_cyc();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        next_cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_before_first_edge", 32'(in_ready), 32'd0);
        next_cyc();

        // rotation: 0,1,2,3,0,1,2,3 (fixed priority: always 0)
        for (int i = 0; i < 8; i++)
            issue(RR ? i % 4 : 0, 32'hA0);

        // backpressure holding source 1
        set_in(4'b0010, 32'hA0);
        issue(1, 32'hA0);
        out_ready = 1'b0;
        set_in(4'b1111, 32'hA0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", out_data, 32'hA1);
            chk("bp_out_sel", 32'(out_sel), 32'd1);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            next_cyc();
        end
        out_ready = 1'b1;
        issue(RR ? 2 : 0, 32'hA0);

        // sparse requests with ptr moved to 1
        set_in(4'b0001, 32'hB0);
        issue(0, 32'hB0);
        set_in(4'b1001, 32'hB0);
        issue(RR ? 3 : 0, 32'hB0);
        issue(0, 32'hB0);

        // flush with out_valid, out_ready and all inputs high
        set_in(4'b1111, 32'hA0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_out_valid_pre", 32'(out_valid), 32'd1);
        next_cyc();
        flush = 1'b0;
        set_in(4'b0000, 32'hA0);
        @(negedge clk);
        chk("flush_out_valid_post", 32'(out_valid), 32'd0);
        next_cyc();
        s = RR ? 1 : 0;
        set_in(4'b1111, 32'hA0);
        issue(s, 32'hA0);

        // idle drain
        set_in(4'b0000, 32'hA0);
        @(negedge clk);
        chk("drain_valid_1", 32'(out_valid), 32'd1);
        next_cyc();
        @(negedge clk);
        chk("drain_valid_0", 32'(out_valid), 32'd0);
        chk("drain_data_kept", out_data, 32'hA0 + 32'(s));
        next_cyc();

        // reset mid-operation with a pending entry
        out_ready = 1'b0;
        set_in(4'b1111, 32'hA0);
        next_cyc();
        @(negedge clk);
        chk("pend_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_sel", 32'(out_sel), 32'd0);
        next_cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_rdy_pre_edge", 32'(in_ready), 32'd0);
        next_cyc();
        issue(0, 32'hA0);
        set_in(4'b0000, 32'hA0);
        repeat (3) next_cyc();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
